perf_counter_ctrl: RTL

Controller and bank for the pipeline performance counters: stall cycles, cache hits and misses, and correct and incorrect branch predictions. It owns `NUM_CNT` event counters with per-counter enables and sticky overflow flags. A single memory-mapped request/response port lets software read, preset/clear and enable each counter. It sits beside the datapath: the hazard unit, cache controllers and branch predictor drive `event_in`, and the CPU data-memory path drives the MMIO port.

---
 rtl/perf_counter_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/perf_counter_ctrl.sv
// Pipeline performance counter bank with per-counter enable, sticky overflow
// flags and a three-state MMIO request/response port.
module perf_counter_ctrl #(
  parameter int NUM_CNT = 8,
  parameter int WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_CNT-1:0] event_in,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [3:0]         mem_addr,
  input  logic [WIDTH-1:0]   mem_wdata,
  output logic [WIDTH-1:0]   mem_rdata,
  output logic               mem_resp
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0] ADDR_ENABLE = 4'd14;
  localparam logic [3:0] ADDR_OVF    = 4'd15;

  logic [1:0]                    state_reg, state_next;
  logic [3:0]                    addr_reg;
  logic [WIDTH-1:0]              wdata_reg;
  logic                          wr_reg;
  logic [WIDTH-1:0]              rdata_reg;
  logic [NUM_CNT-1:0][WIDTH-1:0] cnt_reg, cnt_next;
  logic [NUM_CNT-1:0]            en_reg, en_next;
  logic [NUM_CNT-1:0]            ovf_reg, ovf_next;
  logic [NUM_CNT-1:0]            wdata_mask;
  logic [WIDTH-1:0]              en_rd, ovf_rd, rd_val;

  logic access_wr, access_rd, en_wr, ovf_wr;

  assign access_wr = (state_reg == ACCESS) &&  wr_reg;
  assign access_rd = (state_reg == ACCESS) && !wr_reg;
  assign en_wr     = access_wr && (addr_reg == ADDR_ENABLE);
  assign ovf_wr    = access_wr && (addr_reg == ADDR_OVF);

  // Width adapters between the NUM_CNT-bit masks and the WIDTH-bit data bus.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_wmask
      if (gi < WIDTH) begin : g_in
        assign wdata_mask[gi] = wdata_reg[gi];
      end else begin : g_out
        assign wdata_mask[gi] = 1'b0;
      end
    end
    for (gi = 0; gi < WIDTH; gi++) begin : g_rmask
      if (gi < NUM_CNT) begin : g_in
        assign en_rd[gi]  = en_reg[gi];
        assign ovf_rd[gi] = ovf_reg[gi];
      end else begin : g_out
        assign en_rd[gi]  = 1'b0;
        assign ovf_rd[gi] = 1'b0;
      end
    end
  endgenerate

  // Preset beats a same-cycle event; a wrap beats a same-cycle OVF clear.
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      logic inc, preset, wrap;
      assign inc    = event_in[gi] & en_reg[gi];
      assign preset = access_wr && (addr_reg == 4'(gi));
      assign wrap   = inc & ~preset & (&cnt_reg[gi]);
      assign cnt_next[gi] = preset ? wdata_reg
                          : (inc ? cnt_reg[gi] + WIDTH'(1) : cnt_reg[gi]);
      assign ovf_next[gi] = wrap | (ovf_reg[gi] & ~(ovf_wr & wdata_mask[gi]));
    end
  endgenerate

  assign en_next = en_wr ? wdata_mask : en_reg;

  always_comb begin
    rd_val = '0;
    if (addr_reg == ADDR_ENABLE) begin
      rd_val = en_rd;
    end else if (addr_reg == ADDR_OVF) begin
      rd_val = ovf_rd;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (addr_reg == 4'(i)) rd_val = cnt_reg[i];
      end
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = (mem_read || mem_write) ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wr_reg    <= 1'b0;
      rdata_reg <= '0;
      cnt_reg   <= '0;
      en_reg    <= '1;
      ovf_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      en_reg    <= en_next;
      ovf_reg   <= ovf_next;
      if (state_reg == IDLE && (mem_read || mem_write)) begin
        addr_reg  <= mem_addr;
        wdata_reg <= mem_wdata;
        wr_reg    <= ~mem_read;
      end
      if (access_rd) rdata_reg <= rd_val;
    end
  end

  assign mem_rdata = rdata_reg;
  assign mem_resp  = (state_reg == RESP);

endmodule
